// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sequencer sharing one 32-bit ALU
// among NUM_REQ requesters, one operation in flight at a time.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic [3*NUM_REQ-1:0]  req_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [ID_W-1:0] r_last;
    logic [ID_W-1:0] r_id;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [2:0]      r_sel;
    logic [31:0]     r_data;
    logic            r_zero;

    logic            w_found;
    logic [ID_W-1:0] w_win;
    logic [ID_W-1:0] w_idx;
    logic [31:0]     w_alu;

    // Scan from farthest to nearest so the requester right after
    // last_grant is the one left standing.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_last) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign req_ready = (rst_n && r_state == S_IDLE && w_found)
                     ? (NUM_REQ'(1) << w_win) : '0;

    always_comb begin
        w_alu = '0;
        case (r_sel)
            3'b000: w_alu = r_a + r_b;
            3'b001: w_alu = r_a - r_b;
            3'b010: w_alu = r_a & r_b;
            3'b011: w_alu = r_a | r_b;
            3'b100: w_alu = r_a ^ r_b;
            3'b101: w_alu = ~r_a;
            3'b110: w_alu = {r_a[30:0], 1'b0};
            3'b111: w_alu = {1'b0, r_a[31:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= ID_W'(NUM_REQ - 1);
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= '0;
            r_data  <= '0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a     <= req_a[32*w_win +: 32];
                        r_b     <= req_b[32*w_win +: 32];
                        r_sel   <= req_sel[3*w_win +: 3];
                        r_id    <= w_win;
                        r_last  <= w_win;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_data  <= w_alu;
                    r_zero  <= (w_alu == 32'd0);
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;
    assign rsp_zero  = r_zero;

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter and sequencer that shares the single 32-bit, 8-operation ALU datapath among NUM_REQ requesters. It accepts one operation at a time through a valid/ready handshake, latches the operands, and drives the ALU from registered inputs. It registers the result and returns it on a response channel tagged with the requester index. It sits between the issuing units and the shared ALU, and instantiates the ALU internally.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of the requester index, equal to clog2(NUM_REQ).
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  input  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i].
- req_b  input  32*NUM_REQ  operand B, packed the same way.
- req_sel  input  3*NUM_REQ  ALU op select; requester i uses bits [3i+2:3i].
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester that issued the operation.
- rsp_data  output  32  ALU result.
- rsp_zero  output  1  high when rsp_data is 0.

## Operation
- States: IDLE, EXEC, RESP. Encoding is free.
- **IDLE**
  - Arbitrate among the set bits of req_valid, round-robin.
  - Search starts at (last_grant+1) mod NUM_REQ and wraps.
  - Assert req_ready for the winner only; this is combinational from state and req_valid.
  - On the edge: latch the winner's a, b and sel into op regs and its index into id reg. Set last_grant to the winner. Go to EXEC.
  - If no request is valid, stay in IDLE and leave last_grant unchanged.
- **EXEC**
  - The ALU computes from the op regs.
  - On the edge: latch the ALU output into rsp_data, set rsp_zero = (result == 0), go to RESP.
- **RESP**
  - Hold rsp_valid = 1 with rsp_id, rsp_data and rsp_zero stable.
  - When rsp_valid && rsp_ready, go to IDLE on that edge.
  - Otherwise stay in RESP indefinitely, with all outputs held.
- ALU ops, selected by sel:
  - 000: A+B
  - 001: A−B
  - 010: AND
  - 011: OR
  - 100: XOR
  - 101: ~A
  - 110: A<<1
  - 111: A>>1, logical
- Width rules:
  - All arithmetic is 32-bit, mod 2^32.
  - Carry and borrow are discarded.
  - Shift-out bits are lost; the vacated bit is 0.
- req_ready is 0 in EXEC and RESP. Requesters hold valid and operands stable until they see ready.
- A requester that deasserts valid before it is granted is simply skipped. No state is kept per requester.
- Only one operation is in flight at a time.

## Timing
- Reset values (asynchronous assertion while rst_n = 0):
  - state = IDLE
  - last_grant = NUM_REQ−1, so requester 0 has top priority after reset
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_zero = 0
  - req_ready = 0 for as long as rst_n is low
- Reset release: behaviour is synchronous from the first rising edge with rst_n = 1.
- Latency: the acceptance edge is T0. The EXEC edge is T1. rsp_valid is high in the cycle after T1, i.e. 2 cycles after acceptance.
- Minimum issue interval is 3 cycles: IDLE → EXEC → RESP with rsp_ready = 1 → IDLE.
- A request presented in the cycle RESP completes is not accepted that cycle. It is arbitrated in the following IDLE cycle.
- Reset mid-operation, in EXEC or RESP: the in-flight op is dropped and no response is issued. After release, priority restarts at requester 0.
- Simultaneous events:
  - The request of the just-granted requester is not eligible again until every other valid requester has been served. This is the rotation rule.
  - Back-pressure on rsp_ready does not disturb the latched result or rsp_id.

## Test plan
- **Single ADD:** reset, then req0 valid with a=5, b=3, sel=000.
  - req_ready=0001 in the first IDLE cycle.
  - Two cycles later: rsp_valid=1, rsp_id=0, rsp_data=8, rsp_zero=0.
- **SUB wrap and zero flag:** req2 with a=3, b=5, sel=001 → rsp_data=0xFFFFFFFE, rsp_id=2.
  - Then req1 with a=0x80000000, sel=110 → rsp_data=0, rsp_zero=1.
- **Full contention:** all 4 valid continuously with distinct ops, rsp_ready=1.
  - Grants go 0,1,2,3,0, each 3 cycles apart.
  - Each rsp_id matches its grant, and each result is correct per sel.
- **Rotation skip:** last_grant=1, only req1 and req3 valid.
  - Next grant is 3, then 1.
  - A req0 that is valid for only one non-IDLE cycle is never granted.
- **Back-pressure:** rsp_ready=0 for 5 cycles in RESP with req1 waiting.
  - rsp_data and rsp_id are stable and req_ready=0 throughout.
  - req1 is accepted in the cycle after rsp_ready=1 completes the response.
- **Reset mid-op:** assert rst_n=0 during EXEC.
  - rsp_valid stays 0 and all outputs are at their reset values.
  - After release, with req0 and req3 valid, req0 is granted first.
